// File: rtl/hz_pkg.sv
// Shared encodings and the scoreboard entry type for the ID-stage hazard unit.
// The entry field widths fix the register-address and tnew widths used by hazard_scoreboard.
package hz_pkg;

  localparam int HZ_RAW      = 5;
  localparam int HZ_TW       = 2;
  localparam int FWD_RF      = 0;
  localparam int HZ_MULT_CYC = 5;
  localparam int HZ_DIV_CYC  = 10;

  localparam logic [HZ_TW-1:0] TUSE_NEVER = '1;

  typedef struct packed {
    logic [HZ_RAW-1:0] a3;
    logic              we;
    logic [HZ_TW-1:0]  tnew;
  } sb_entry_t;

endpackage

// File: rtl/md_busy_timer.sv
// Countdown timer for the multi-cycle mult/div unit; busy while the count is nonzero.
module md_busy_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [CW-1:0] load_val,
  output logic          busy
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load_en) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall/forward controller backed by a shifting scoreboard of in-flight writers.
// Optional stall-cycle counter is built only when HZ_STALL_COUNTER_EN is defined.
module hazard_scoreboard
  import hz_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int RAW      = HZ_RAW,
  parameter int TW       = HZ_TW,
  parameter int MULT_CYC = HZ_MULT_CYC,
  parameter int DIV_CYC  = HZ_DIV_CYC,
  parameter int FSW      = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic [TW-1:0]  id_tuse_rs,
  input  logic [TW-1:0]  id_tuse_rt,
  input  logic [RAW-1:0] id_a3,
  input  logic           id_regwrite,
  input  logic [TW-1:0]  id_tnew,
  input  logic           id_md_type,
  input  logic           id_md_start,
  input  logic           id_md_div,
  output logic           stall,
  output logic [FSW-1:0] fwd_rs_sel,
  output logic [FSW-1:0] fwd_rt_sel,
  output logic           md_busy,
  output logic [31:0]    stall_cnt
);

  localparam int MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW     = $clog2(MD_MAX + 1);

  sb_entry_t sb [1:STAGES];
  logic      hz_rs;
  logic      hz_rt;
  logic      issue;
  logic      md_load;
  logic [CW-1:0] md_load_val;

  function automatic logic [HZ_TW-1:0] tnew_dec_sat(input logic [HZ_TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic src_match(input sb_entry_t e, input logic [RAW-1:0] src);
    return e.we && (e.a3 == src) && (src != '0);
  endfunction

  // Hazard compare: walk oldest to youngest so the youngest matching stage wins the select
  always_comb begin
    hz_rs      = 1'b0;
    hz_rt      = 1'b0;
    fwd_rs_sel = FSW'(FWD_RF);
    fwd_rt_sel = FSW'(FWD_RF);
    for (int k = STAGES; k >= 1; k--) begin
      if (src_match(sb[k], id_rs)) begin
        fwd_rs_sel = FSW'(k);
        if (id_tuse_rs < sb[k].tnew) hz_rs = 1'b1;
      end
      if (src_match(sb[k], id_rt)) begin
        fwd_rt_sel = FSW'(k);
        if (id_tuse_rt < sb[k].tnew) hz_rt = 1'b1;
      end
    end
  end

  assign stall = id_valid & (hz_rs | hz_rt | (id_md_type & md_busy));
  assign issue = id_valid & ~stall;

  // Scoreboard shift: a3 is pure data, only we/tnew are cleared by reset
  always_ff @(posedge clk) begin
    for (int k = STAGES; k >= 2; k--) begin
      sb[k].a3 <= sb[k-1].a3;
    end
    sb[1].a3 <= id_a3;
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        sb[k].we   <= 1'b0;
        sb[k].tnew <= '0;
      end
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        sb[k].we   <= sb[k-1].we;
        sb[k].tnew <= tnew_dec_sat(sb[k-1].tnew);
      end
      sb[1].we   <= issue & id_regwrite & (id_a3 != '0);
      sb[1].tnew <= issue ? id_tnew : '0;
    end
  end

  assign md_load     = issue & id_md_start;
  assign md_load_val = id_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);

  md_busy_timer #(
    .CW(CW)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .load_en (md_load),
    .load_val(md_load_val),
    .busy    (md_busy)
  );

`ifdef HZ_STALL_COUNTER_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus mult/div and reset sequences.
module tb_hazard_scoreboard;
  import hz_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_a3;
  logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
  logic       id_regwrite, id_md_type, id_md_start, id_md_div;
  logic       stall, md_busy;
  logic [2:0] fwd_rs_sel, fwd_rt_sel;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .STAGES(3), .RAW(5), .TW(2), .MULT_CYC(5), .DIV_CYC(10), .FSW(3)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_a3(id_a3),
    .id_regwrite(id_regwrite), .id_tnew(id_tnew), .id_md_type(id_md_type),
    .id_md_start(id_md_start), .id_md_div(id_md_div), .stall(stall),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [1:0] trs;
    logic [4:0] rt;
    logic [1:0] trt;
    logic [4:0] a3;
    logic       rw;
    logic [1:0] tnew;
    logic       e_stall;
    logic [2:0] e_rs;
    logic [2:0] e_rt;
  } vec_t;

  vec_t tbl [13];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                              input logic [4:0] rt, input logic [1:0] trt, input logic [4:0] a3,
                              input logic rw, input logic [1:0] tnew, input logic es,
                              input logic [2:0] ers, input logic [2:0] ert);
    vec_t r;
    r.v = v; r.rs = rs; r.trs = trs; r.rt = rt; r.trt = trt; r.a3 = a3;
    r.rw = rw; r.tnew = tnew; r.e_stall = es; r.e_rs = ers; r.e_rt = ert;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt, input logic [4:0] a3,
                       input logic rw, input logic [1:0] tnew, input logic mdt,
                       input logic mds, input logic mdd);
    id_valid = v; id_rs = rs; id_tuse_rs = trs; id_rt = rt; id_tuse_rt = trt;
    id_a3 = a3; id_regwrite = rw; id_tnew = tnew;
    id_md_type = mdt; id_md_start = mds; id_md_div = mdd;
  endtask

  // Check outputs mid-cycle, then advance past the next rising edge.
  task automatic cycle_chk(input string nm, input logic es, input logic [2:0] ers,
                           input logic [2:0] ert, input logic eb);
    @(negedge clk);
    chk({nm, " stall"}, {31'd0, stall}, {31'd0, es});
    chk({nm, " fwd_rs"}, {29'd0, fwd_rs_sel}, {29'd0, ers});
    chk({nm, " fwd_rt"}, {29'd0, fwd_rt_sel}, {29'd0, ert});
    chk({nm, " md_busy"}, {31'd0, md_busy}, {31'd0, eb});
    if (es) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic md_case(input logic is_div, input int n);
    drive(1, 5'd11, 2'd0, 5'd12, 2'd0, 5'd0, 0, 2'd0, 1, 1, is_div);
    cycle_chk("md start", 0, 0, 0, 0);
    drive(1, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd13, 1, 2'd1, 1, 0, 0);
    for (int i = 0; i < n; i++) cycle_chk($sformatf("md wait%0d", i), 1, 0, 0, 1);
    cycle_chk("md issue", 0, 0, 0, 0);
    drive(0, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd0, 0, 2'd0, 0, 0, 0);
    cycle_chk("md after", 0, 0, 0, 0);
  endtask

  task automatic load_use_case();
    drive(1, 5'd1, 2'd1, 5'd0, TUSE_NEVER, 5'd8, 1, 2'd2, 0, 0, 0);
    cycle_chk("lu lw", 0, 0, 0, 0);
    drive(1, 5'd8, 2'd1, 5'd2, 2'd1, 5'd10, 1, 2'd1, 0, 0, 0);
    cycle_chk("lu add stalled", 1, 1, 0, 0);
    cycle_chk("lu add issue", 0, 2, 0, 0);
  endtask

  initial begin
    tbl[0]  = mk(1, 5'd1,  2'd1, 5'd0,  TUSE_NEVER, 5'd8,  1, 2'd2, 0, 0, 0);
    tbl[1]  = mk(1, 5'd8,  2'd1, 5'd2,  2'd1,       5'd10, 1, 2'd1, 1, 1, 0);
    tbl[2]  = mk(1, 5'd8,  2'd1, 5'd2,  2'd1,       5'd10, 1, 2'd1, 0, 2, 0);
    tbl[3]  = mk(1, 5'd0,  2'd1, 5'd0,  TUSE_NEVER, 5'd5,  1, 2'd1, 0, 0, 0);
    tbl[4]  = mk(1, 5'd10, 2'd0, 5'd5,  2'd0,       5'd0,  0, 2'd0, 1, 2, 1);
    tbl[5]  = mk(1, 5'd10, 2'd0, 5'd5,  2'd0,       5'd0,  0, 2'd0, 0, 3, 2);
    tbl[6]  = mk(1, 5'd5,  2'd1, 5'd0,  TUSE_NEVER, 5'd6,  1, 2'd1, 0, 3, 0);
    tbl[7]  = mk(1, 5'd6,  2'd1, 5'd6,  2'd1,       5'd7,  1, 2'd1, 0, 1, 1);
    tbl[8]  = mk(1, 5'd7,  2'd1, 5'd0,  TUSE_NEVER, 5'd0,  1, 2'd1, 0, 1, 0);
    tbl[9]  = mk(1, 5'd0,  2'd0, 5'd0,  2'd0,       5'd9,  1, 2'd1, 0, 0, 0);
    tbl[10] = mk(1, 5'd9,  2'd1, 5'd7,  2'd1,       5'd9,  1, 2'd1, 0, 1, 3);
    tbl[11] = mk(0, 5'd9,  2'd0, 5'd9,  2'd0,       5'd0,  0, 2'd0, 0, 1, 1);
    tbl[12] = mk(1, 5'd9,  2'd1, 5'd0,  TUSE_NEVER, 5'd0,  0, 2'd0, 0, 2, 0);

    reset = 1'b1;
    drive(0, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd0, 0, 2'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset fwd_rs", {29'd0, fwd_rs_sel}, 32'd0);
    chk("reset md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].trs, tbl[i].rt, tbl[i].trt, tbl[i].a3,
            tbl[i].rw, tbl[i].tnew, 0, 0, 0);
      cycle_chk($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_rs, tbl[i].e_rt, 0);
    end
`ifdef HZ_STALL_COUNTER_EN
    chk("table stall_cnt", stall_cnt, exp_cnt);
`else
    chk("table stall_cnt", stall_cnt, 32'd0);
`endif

    md_case(1'b1, 10);
    md_case(1'b0, 5);

    // Fill the scoreboard behind a div, then reset with the timer at 7.
    drive(1, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd0, 0, 2'd0, 1, 1, 1);
    cycle_chk("rst div", 0, 0, 0, 0);
    drive(1, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd20, 1, 2'd2, 0, 0, 0);
    cycle_chk("rst w20", 0, 0, 0, 1);
    drive(1, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd21, 1, 2'd2, 0, 0, 0);
    cycle_chk("rst w21", 0, 0, 0, 1);
    drive(1, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd22, 1, 2'd2, 0, 0, 0);
    cycle_chk("rst w22", 0, 0, 0, 1);
    drive(1, 5'd22, 2'd0, 5'd21, 2'd0, 5'd0, 0, 2'd0, 1, 0, 0);
    @(negedge clk);
    chk("pre-rst stall", {31'd0, stall}, 32'd1);
    chk("pre-rst fwd_rs", {29'd0, fwd_rs_sel}, 32'd1);
    chk("pre-rst fwd_rt", {29'd0, fwd_rt_sel}, 32'd2);
    chk("pre-rst md_busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("post-rst stall", {31'd0, stall}, 32'd0);
    chk("post-rst fwd_rs", {29'd0, fwd_rs_sel}, 32'd0);
    chk("post-rst fwd_rt", {29'd0, fwd_rt_sel}, 32'd0);
    chk("post-rst md_busy", {31'd0, md_busy}, 32'd0);
    chk("post-rst stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    drive(0, 5'd0, TUSE_NEVER, 5'd0, TUSE_NEVER, 5'd0, 0, 2'd0, 0, 0, 0);
    cycle_chk("post-rst idle", 0, 0, 0, 0);

    load_use_case();
    md_case(1'b1, 10);
`ifdef HZ_STALL_COUNTER_EN
    chk("final stall_cnt", stall_cnt, 32'd11);
`else
    chk("final stall_cnt", stall_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational stall/forward controller.
- Holds a sequential scoreboard of in-flight writers for STAGES post-decode stages. Each entry carries a destination register, a write flag and a self-decrementing tnew.
- Also owns a multi-cycle mult/div busy timer.
- Sits beside the ID stage. Produces stall for the IF/ID enable and bubble insert, plus forward selects for the ID-stage rs/rt operand muxes.

Parameters:
- STAGES, 3: number of tracked stages after ID (EX, MEM, WB…); legal range 1-6.
- RAW, 5: register address width.
- TW, 2: tnew/tuse width; the all-ones value of tuse means "never used".
- MULT_CYC, 5: busy cycles for mult/multu.
- DIV_CYC, 10: busy cycles for div/divu.
- FSW, 3: forward-select width; must satisfy 2^FSW > STAGES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  RAW  source register 1
- id_rt  in  RAW  source register 2
- id_tuse_rs  in  TW  cycles until rs is needed
- id_tuse_rt  in  TW  cycles until rt is needed
- id_a3  in  RAW  destination register
- id_regwrite  in  1  instruction writes the register file
- id_tnew  in  TW  tnew the instruction will have on entering stage 1 (EX)
- id_md_type  in  1  any mult/div/mfhi/mflo/mthi/mtlo
- id_md_start  in  1  mult/multu/div/divu
- id_md_div  in  1  start is a divide
- stall  out  1  freeze PC and IF/ID, insert bubble into stage 1
- fwd_rs_sel  out  FSW  0 = register file; k = stage k result
- fwd_rt_sel  out  FSW  same encoding as fwd_rs_sel, for rt
- md_busy  out  1  mult/div timer running
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Scoreboard entry: {a3, we, tnew}; we is forced 0 when a3 == 0.
- Reset (synchronous, active-high):
  - all entries cleared to we=0, tnew=0;
  - timer = 0;
  - stall_cnt = 0.
  - Reset mid-operation discards all in-flight state. Outputs become combinationally stall=0, sels=0, md_busy=0 in the cycle after the reset edge.
- Per clock edge, for k = STAGES down to 2: entry[k] <= entry[k-1], with tnew decremented and saturating at 0.
- Entry[1] load:
  - if id_valid & !stall: entry[1] <= {id_a3, id_regwrite & (id_a3 != 0), id_tnew};
  - otherwise entry[1] <= bubble (we=0).
- The oldest entry retires every cycle. There is no full or empty condition.
- Stall is combinational from current state and ID inputs, and asserts if any of:
  - for src in {rs, rt} and any k: entry[k].we & entry[k].a3 == src & src != 0 & tuse_src < entry[k].tnew;
  - id_md_type & md_busy.
- stall is gated by id_valid.
- fwd_x_sel is combinational:
  - value is the smallest k with entry[k].we & entry[k].a3 == x & x != 0;
  - it is asserted regardless of tnew, because stall covers not-ready data;
  - with no match, the value is 0.
- Mult/div timer:
  - loads MULT_CYC or DIV_CYC (selected by id_md_div) on an edge where id_valid & id_md_start & !stall;
  - otherwise decrements while nonzero;
  - md_busy = (timer != 0), so it is already 1 in the cycle the start instruction sits in EX;
  - a start that is stalled does not load the timer.
- Back-to-back mult/div: a second md-type instruction stalls until the timer reaches 0, then issues and reloads the timer.
- Latency: stall and select outputs have 0-cycle combinational latency from ID inputs, and 1 cycle from issue to scoreboard visibility.

Optional Feature:
- Macro: HZ_STALL_COUNTER_EN.
- Defined: stall_cnt increments by 1 on every edge where stall=1 and reset=0. It wraps modulo 2^32.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package hz_pkg holds:
  - FWD_RF = 0 encoding;
  - TUSE_NEVER = all-ones;
  - default MULT_CYC and DIV_CYC constants;
  - the scoreboard entry struct typedef.
- Sub-module md_busy_timer (load value, load enable, busy out) isolates the countdown.
- Scoreboard shift and hazard compare stay in the top module.

Test Plan:
- Load-use: issue lw $8 (id_tnew=2), then an add using $8 as rs (tuse=1).
  - stall=1 for 1 cycle.
  - Then fwd_rs_sel=2 with stall=0.
- ALU forward: issue ori $5 (tnew=1), then beq using $5 (tuse=0).
  - stall=1 for 1 cycle, then fwd_rs_sel=2.
  - Next-cycle same-register use with tuse=1 gives fwd_rs_sel=1 with no stall.
- $0 and priority:
  - A writer to $0 never stalls or forwards; fwd_rs_sel=0.
  - Two writers to $9 in stages 1 and 2 give fwd_rs_sel=1.
- Mult/div: div issued, then mflo.
  - md_busy=1 for 10 cycles and stall=1 for those 10.
  - mflo issues on the cycle md_busy falls.
  - With mult instead: 5 cycles.
- Reset mid-operation: assert reset while the timer is at 7 and the scoreboard is full.
  - Next cycle: md_busy=0, stall=0, sels=0, stall_cnt=0.
- HZ_STALL_COUNTER_EN: run the lw load-use case, then the div/mflo case.
  - stall_cnt = 11.
  - Without the macro, stall_cnt = 0.
